occ_fetch_unit: RTL and testbench
=================================

# occ_fetch_unit

Occ-table fetch stage sitting directly downstream of the accelerator control FSM's Occ port. It serves the FSM's `ce_rom_Occ` / `addr_rom_Occ` requests from a variable-latency backing memory and returns `data_Occ` with a `data_valid` qualifier. A one-entry tag cache removes the memory round-trip when consecutive searches touch the same Occ row. A saturating miss counter is provided for profiling.

## Interface
- `ADDR_W`, 8: Occ row address width.
- `DATA_W`, 32: Occ row data width.
- `CNT_W`, 16: miss counter width.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ce_rom_Occ` input 1: request from the FSM; held high until `data_valid` is seen.
- `addr_rom_Occ` input ADDR_W: requested row; held stable while `ce_rom_Occ` is high.
- `flush` input 1: one-cycle pulse that invalidates the cache entry.
- `data_Occ` output DATA_W: returned row, registered.
- `data_valid` output 1: `data_Occ` is valid for the current request, registered.
- `mem_req` output 1: one-cycle read strobe to the backing memory.
- `mem_addr` output ADDR_W: backing-memory read address, stable from `mem_req` until `mem_rvalid`.
- `mem_rdata` input DATA_W: backing-memory data.
- `mem_rvalid` input 1: one-cycle pulse; `mem_rdata` is valid in that cycle.
- `miss_count` output CNT_W: number of backing-memory reads issued, saturating.

## Operation
- **Reset values:**
  - `data_Occ` = 0, `data_valid` = 0, `mem_req` = 0, `mem_addr` = 0, `miss_count` = 0.
  - Cache valid = 0, tag = 0, cache data = 0.
  - State = IDLE.
- **States:** IDLE, FETCH, HOLD.
- **IDLE, `ce_rom_Occ` = 0:** stay in IDLE; `data_valid` = 0.
- **IDLE, `ce_rom_Occ` = 1:**
  - Latch `addr_rom_Occ` as `req_addr`.
  - **Hit** (cache valid and tag == `addr_rom_Occ`): load `data_Occ` from the cache, set `data_valid` = 1, go to HOLD.
  - **Miss:** set `mem_req` = 1 for exactly one cycle, set `mem_addr` = `addr_rom_Occ`, increment `miss_count`, go to FETCH.
- **FETCH:**
  - Wait for `mem_rvalid`; there is no timeout.
  - On `mem_rvalid`: write the cache (tag = `mem_addr`, data = `mem_rdata`, valid = 1).
  - If `ce_rom_Occ` is still high with an unchanged address: `data_Occ` = `mem_rdata`, `data_valid` = 1, go to HOLD.
  - Otherwise (request withdrawn or address changed): go to IDLE with `data_valid` = 0. The fill still updates the cache.
- **HOLD:**
  - `data_valid` stays 1 and `data_Occ` stays stable while `ce_rom_Occ` = 1 and `addr_rom_Occ` == `req_addr`.
  - If `ce_rom_Occ` = 0, or the address differs: `data_valid` = 0 next cycle, go to IDLE. The new address is looked up from IDLE on the following cycle.
- **`mem_rvalid` outside FETCH:** ignored.
- **`flush`:**
  - Clears cache valid; does not abort a FETCH in progress.
  - Flush in the same cycle as a fill: flush wins and the entry stays invalid. The FETCH still returns data to the requester.
  - Flush during HOLD: `data_valid` and `data_Occ` are unaffected.
- **`miss_count`:** increments by 1 per `mem_req`. Stays at 2^CNT_W−1 once reached and never wraps.
- **Reset asserted mid-FETCH:** everything returns to reset values immediately. A late `mem_rvalid` arriving after reset release is ignored, because the block is in IDLE.

## Timing
- Cycle n is the first rising edge at which `ce_rom_Occ` = 1 is sampled in IDLE.
- **Hit:** `data_valid` = 1 from cycle n+1. Latency is 1 cycle.
- **Miss:** `mem_req` is high in cycle n+1 only. If `mem_rvalid` arrives in cycle n+1+L (L ≥ 1), `data_valid` = 1 from cycle n+2+L.
- **Drop of `ce_rom_Occ` in HOLD** sampled at edge m: `data_valid` = 0 from cycle m+1.
- **Back-to-back requests:** a new request needs at least one IDLE cycle. A hit therefore costs 2 cycles per request at steady state.
- **Output registers:** every output is driven from a register; there is no combinational path from input to output.

## Test plan
- **Cold miss:** after reset, `ce` = 1, addr = 0x12, memory returns 0xDEADBEEF with L = 3.
  - `mem_req` is high for exactly one cycle with `mem_addr` = 0x12.
  - `data_valid` rises 5 cycles after the request is sampled, with `data_Occ` = 0xDEADBEEF.
  - `miss_count` = 1.
- **Hit:** drop `ce`, then re-request addr 0x12.
  - No `mem_req` is issued.
  - `data_valid` is high the cycle after the request, with `data_Occ` = 0xDEADBEEF.
  - `miss_count` stays 1.
- **Address change and flush:**
  - Request 0x34 → miss.
  - Then request 0x12 → miss, `miss_count` = 3.
  - Pulse `flush`, then request 0x12 → miss, `miss_count` = 4.
- **Withdraw during FETCH:** request 0x56, drop `ce` before `mem_rvalid`.
  - `data_valid` never rises.
  - The next request to 0x56 is a hit with the filled data.
- **Flush coincident with `mem_rvalid`:**
  - The requester still receives the data.
  - The next request to the same address issues `mem_req`.
- **Reset and saturation:**
  - Assert `rst_n` = 0 mid-FETCH: all outputs are 0 asynchronously, and a late `mem_rvalid` produces no `data_valid`.
  - With CNT_W = 2, issue 5 misses: `miss_count` = 3.

Source files
------------

// File: rtl/occ_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : occ_fetch_unit
// Description : Occ-table fetch stage. Serves ce_rom_Occ/addr_rom_Occ
//               requests from a variable-latency backing memory. A one-entry
//               tag cache short-cuts repeated rows, and a saturating counter
//               counts backing-memory reads.
// Revision    : 1.0 - initial release
// ============================================================================
module occ_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_rom_Occ,
  input  logic [ADDR_W-1:0] addr_rom_Occ,
  input  logic              flush,
  output logic [DATA_W-1:0] data_Occ,
  output logic              data_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_tag;
  logic [DATA_W-1:0] cache_data;

  logic hit;
  logic same_req;
  logic fill;
  logic issue;

  // Lookup uses the registered valid bit: a flush in the same cycle as a
  // lookup only affects lookups from the next cycle on.
  assign hit      = cache_valid && (cache_tag == addr_rom_Occ);
  assign same_req = ce_rom_Occ && (addr_rom_Occ == req_addr);
  assign fill     = (state == ST_FETCH) && mem_rvalid;
  assign issue    = (state == ST_IDLE) && ce_rom_Occ && !hit;

  // Request FSM with registered outputs towards the requester and memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_addr   <= '0;
      data_Occ   <= '0;
      data_valid <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_valid <= 1'b0;
          mem_req    <= 1'b0;
          if (ce_rom_Occ) begin
            req_addr <= addr_rom_Occ;
            if (hit) begin
              data_Occ   <= cache_data;
              data_valid <= 1'b1;
              state      <= ST_HOLD;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= addr_rom_Occ;
              state    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // The read strobe is a single-cycle pulse; mem_addr stays put.
          mem_req <= 1'b0;
          if (mem_rvalid) begin
            if (same_req) begin
              data_Occ   <= mem_rdata;
              data_valid <= 1'b1;
              state      <= ST_HOLD;
            end else begin
              // Requester moved on; the fill only warms the cache.
              data_valid <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          mem_req <= 1'b0;
          if (!same_req) begin
            data_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          data_valid <= 1'b0;
          mem_req    <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // One-entry cache: filled by memory returns, invalidated by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else begin
      if (fill) begin
        cache_tag  <= mem_addr;
        cache_data <= mem_rdata;
      end
      // Flush has priority over a coincident fill.
      if (flush) begin
        cache_valid <= 1'b0;
      end else if (fill) begin
        cache_valid <= 1'b1;
      end
    end
  end

  // Saturating count of backing-memory reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (issue && !(&miss_count)) begin
      miss_count <= miss_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_occ_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_occ_fetch_unit
// Description : Self-checking bench for occ_fetch_unit. Two instances share
//               the stimulus; the second uses a 2-bit miss counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_occ_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [7:0]  addr;
  logic        flush;
  logic [31:0] rdata;
  logic        rvalid;

  logic [31:0] data_a;
  logic        dv_a;
  logic        req_a;
  logic [7:0]  maddr_a;
  logic [15:0] cnt_a;

  logic [31:0] data_b;
  logic        dv_b;
  logic        req_b;
  logic [7:0]  maddr_b;
  logic [1:0]  cnt_b;

  occ_fetch_unit #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce_rom_Occ(ce), .addr_rom_Occ(addr),
    .flush(flush), .data_Occ(data_a), .data_valid(dv_a), .mem_req(req_a),
    .mem_addr(maddr_a), .mem_rdata(rdata), .mem_rvalid(rvalid),
    .miss_count(cnt_a)
  );

  occ_fetch_unit #(.ADDR_W(8), .DATA_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .ce_rom_Occ(ce), .addr_rom_Occ(addr),
    .flush(flush), .data_Occ(data_b), .data_valid(dv_b), .mem_req(req_b),
    .mem_addr(maddr_b), .mem_rdata(rdata), .mem_rvalid(rvalid),
    .miss_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: cache contents, memory image and miss total.
  bit          m_valid;
  logic [7:0]  m_tag;
  logic [31:0] m_data;
  int          misses;
  logic [31:0] memv [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts();
    chk("miss_count", 64'(cnt_a), 64'(misses));
    chk("miss_count_sat", 64'(cnt_b), 64'((misses > 3) ? 3 : misses));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_valid = 1'b0;
  endtask

  // One complete request: lookup, optional memory return, hold, release.
  task automatic do_req(input logic [7:0] a, input int lat, input bit flush_fill,
                        input int hold, input bit flush_hold);
    bit          is_hit;
    logic [31:0] exp_data;
    is_hit = m_valid && (m_tag == a);
    ce   = 1'b1;
    addr = a;
    @(negedge clk);
    if (is_hit) begin
      exp_data = m_data;
      chk("hit_valid", 64'(dv_a), 64'd1);
      chk("hit_data", 64'(data_a), 64'(exp_data));
      chk("hit_noreq", 64'(req_a), 64'd0);
    end else begin
      misses++;
      exp_data = memv[a];
      chk("miss_req", 64'(req_a), 64'd1);
      chk("miss_addr", 64'(maddr_a), 64'(a));
      chk("miss_dv", 64'(dv_a), 64'd0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        chk("fetch_noreq", 64'(req_a), 64'd0);
        chk("fetch_addr", 64'(maddr_a), 64'(a));
        chk("fetch_dv", 64'(dv_a), 64'd0);
      end
      rvalid = 1'b1;
      rdata  = memv[a];
      flush  = flush_fill;
      @(negedge clk);
      rvalid = 1'b0;
      flush  = 1'b0;
      rdata  = $urandom;
      chk("fill_valid", 64'(dv_a), 64'd1);
      chk("fill_data", 64'(data_a), 64'(exp_data));
      if (flush_fill) begin
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_tag   = a;
        m_data  = memv[a];
      end
    end
    chk_counts();
    for (int i = 0; i < hold; i++) begin
      if (flush_hold && i == 0) flush = 1'b1;
      @(negedge clk);
      if (flush) m_valid = 1'b0;
      flush = 1'b0;
      chk("hold_valid", 64'(dv_a), 64'd1);
      chk("hold_data", 64'(data_a), 64'(exp_data));
    end
    ce = 1'b0;
    @(negedge clk);
    chk("release_dv", 64'(dv_a), 64'd0);
  endtask

  // Miss whose requester withdraws before the memory answers.
  task automatic do_withdraw(input logic [7:0] a, input int lat);
    if (m_valid && m_tag == a) pulse_flush();
    ce   = 1'b1;
    addr = a;
    @(negedge clk);
    misses++;
    chk("wd_req", 64'(req_a), 64'd1);
    ce = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wd_dv_wait", 64'(dv_a), 64'd0);
    end
    rvalid = 1'b1;
    rdata  = memv[a];
    @(negedge clk);
    rvalid = 1'b0;
    chk("wd_dv_fill", 64'(dv_a), 64'd0);
    @(negedge clk);
    chk("wd_dv_after", 64'(dv_a), 64'd0);
    m_valid = 1'b1;
    m_tag   = a;
    m_data  = memv[a];
    chk_counts();
  endtask

  // Memory return with no fetch outstanding must change nothing.
  task automatic stray_rvalid();
    rvalid = 1'b1;
    rdata  = $urandom;
    @(negedge clk);
    rvalid = 1'b0;
    chk("stray_dv", 64'(dv_a), 64'd0);
    chk("stray_req", 64'(req_a), 64'd0);
  endtask

  initial begin
    logic [7:0] pool [4];
    logic [7:0] a;
    int         r;
    rst_n  = 1'b0;
    ce     = 1'b0;
    addr   = 8'h00;
    flush  = 1'b0;
    rdata  = 32'h0;
    rvalid = 1'b0;
    m_valid = 1'b0;
    m_tag   = 8'h00;
    m_data  = 32'h0;
    misses  = 0;
    for (int i = 0; i < 256; i++) memv[i] = $urandom;
    memv[8'h12] = 32'hDEADBEEF;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_dv", 64'(dv_a), 64'd0);
    chk("rst_req", 64'(req_a), 64'd0);
    chk("rst_maddr", 64'(maddr_a), 64'd0);
    chk("rst_data", 64'(data_a), 64'd0);
    chk_counts();
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, then hit on the same row
    do_req(8'h12, 3, 1'b0, 2, 1'b0);
    chk("cold_miss_cnt", 64'(cnt_a), 64'd1);
    do_req(8'h12, 3, 1'b0, 1, 1'b0);
    chk("hit_cnt", 64'(cnt_a), 64'd1);

    // Address change, then flush forcing a re-fetch
    do_req(8'h34, 2, 1'b0, 0, 1'b0);
    do_req(8'h12, 1, 1'b0, 0, 1'b0);
    chk("addr_change_cnt", 64'(cnt_a), 64'd3);
    pulse_flush();
    do_req(8'h12, 2, 1'b0, 0, 1'b0);
    chk("flush_cnt", 64'(cnt_a), 64'd4);

    // Withdraw during fetch still warms the cache
    do_withdraw(8'h56, 2);
    do_req(8'h56, 1, 1'b0, 1, 1'b0);
    chk("wd_hit_cnt", 64'(cnt_a), 64'd5);

    // Flush coincident with the fill
    do_req(8'h78, 2, 1'b1, 1, 1'b0);
    do_req(8'h78, 1, 1'b0, 0, 1'b0);
    chk("flush_fill_cnt", 64'(cnt_a), 64'd7);

    // Flush during hold leaves outputs alone but kills the entry
    do_req(8'h78, 1, 1'b0, 2, 1'b1);
    do_req(8'h78, 2, 1'b0, 0, 1'b0);

    // Randomized mix over a small address pool
    pool[0] = 8'h12; pool[1] = 8'h34; pool[2] = 8'h9A; pool[3] = 8'hFF;
    for (int it = 0; it < 60; it++) begin
      a = pool[$urandom_range(0, 3)];
      r = int'($urandom_range(0, 9));
      case (r)
        0: do_withdraw(a, int'($urandom_range(1, 4)));
        1: begin pulse_flush(); do_req(a, int'($urandom_range(1, 4)), 1'b0, 1, 1'b0); end
        2: do_req(a, int'($urandom_range(1, 4)), 1'b1, 1, 1'b0);
        3: do_req(a, int'($urandom_range(1, 4)), 1'b0, 2, 1'b1);
        4: begin stray_rvalid(); do_req(a, int'($urandom_range(1, 4)), 1'b0, 0, 1'b0); end
        default: do_req(a, int'($urandom_range(1, 4)), 1'b0, int'($urandom_range(0, 3)), 1'b0);
      endcase
    end

    // Reset asserted mid-fetch
    if (m_valid && m_tag == 8'hC3) pulse_flush();
    ce   = 1'b1;
    addr = 8'hC3;
    @(negedge clk);
    chk("rstf_req", 64'(req_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstf_dv", 64'(dv_a), 64'd0);
    chk("rstf_req0", 64'(req_a), 64'd0);
    chk("rstf_maddr", 64'(maddr_a), 64'd0);
    chk("rstf_data", 64'(data_a), 64'd0);
    chk("rstf_cnt", 64'(cnt_a), 64'd0);
    chk("rstf_cnt_sat", 64'(cnt_b), 64'd0);
    ce = 1'b0;
    m_valid = 1'b0;
    misses  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_rvalid();
    @(negedge clk);
    chk("late_rvalid_dv", 64'(dv_a), 64'd0);
    // Late data must not have filled the cache
    do_req(8'hC3, 1, 1'b0, 0, 1'b0);

    // Saturation of the 2-bit counter
    for (int i = 1; i <= 5; i++) do_req(8'(i), 1, 1'b0, 0, 1'b0);
    chk("sat_cnt", 64'(cnt_b), 64'd3);
    chk("nosat_cnt", 64'(cnt_a), 64'd6);
    chk("sat_dv_b", 64'(dv_b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
